// File: rtl/serial_frame_collector.sv
// Deserialiser for start/data/stop framed bits coming off an ms_sr_flip_flop
// stage; samples only on en strobes and reports good words or framing errors.
module serial_frame_collector #(
  parameter int DATA_W = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D_in,
  input  logic              en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);
  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP, WAIT_HIGH} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_err;
  logic              r_busy;
  logic [7:0]        r_cnt;
  logic              w_bit;

  // Qbar-driven lines are flipped here so the framing logic always sees idle=1.
  assign w_bit = D_in ^ INVERT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (en) begin
        unique case (r_state)
          IDLE: begin
            if (!w_bit) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
            end
          end
          DATA: begin
            // LSB arrives first, so shifting in at the top leaves it at bit 0.
            r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) r_state <= STOP;
          end
          STOP: begin
            r_busy <= 1'b0;
            if (w_bit) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_cnt   <= r_cnt + 8'd1;
              r_state <= IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= WAIT_HIGH;
            end
          end
          WAIT_HIGH: begin
            // A line stuck low after a bad stop must not look like a start bit.
            if (w_bit) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_err = r_err;
  assign frame_cnt = r_cnt;
endmodule

// File: tb/tb_serial_frame_collector.sv
// Directed bench for serial_frame_collector: a normal instance plus an INVERT=1
// instance fed the complemented line.
module tb_serial_frame_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d_in = 1'b1;
  logic en = 1'b0;
  logic d_in_inv;
  logic [7:0] data_out, data_out_i, frame_cnt, frame_cnt_i;
  logic valid, busy, frame_err, valid_i, busy_i, frame_err_i;

  int vectors = 0;
  int miscompares = 0;
  int n_valid, n_err, n_busy, n_valid_i;
  int n_both = 0;

  assign d_in_inv = ~d_in;
  always #5 clk = ~clk;

  serial_frame_collector #(.DATA_W(8), .INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .D_in(d_in), .en(en),
    .data_out(data_out), .valid(valid), .busy(busy),
    .frame_err(frame_err), .frame_cnt(frame_cnt));

  serial_frame_collector #(.DATA_W(8), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .D_in(d_in_inv), .en(en),
    .data_out(data_out_i), .valid(valid_i), .busy(busy_i),
    .frame_err(frame_err_i), .frame_cnt(frame_cnt_i));

  task automatic clear_counts();
    n_valid = 0; n_err = 0; n_busy = 0; n_valid_i = 0;
  endtask

  // Drive one bit, take the edge, then tally outputs 1 ns later.
  task automatic step(input logic b, input logic e);
    d_in = b; en = e;
    @(posedge clk); #1;
    n_valid   += int'(valid);
    n_err     += int'(frame_err);
    n_busy    += int'(busy);
    n_valid_i += int'(valid_i);
    n_both    += int'(valid & frame_err);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stopb);
    step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(w[i], 1'b1);
    step(stopb, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d_in = 1'b1; en = 1'b1;
    #3;
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    vectors++; if ({valid, busy, frame_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {valid, busy, frame_err}); end
    vectors++; if (frame_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_frame_cnt: got %h want 00", frame_cnt); end
    vectors++; if ({data_out_i, frame_cnt_i} !== 16'h0000) begin miscompares++; $display("FAIL reset_inv: got %h want 0000", {data_out_i, frame_cnt_i}); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_counts();
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    vectors++; if (n_busy + n_valid + n_err !== 0) begin miscompares++; $display("FAIL reset_idle: got %0d activity want 0", n_busy + n_valid + n_err); end
  endtask

  // Start bit, then the listed stream 0,1,0,1,0,0,1,0 (data, LSB first), stop 1, idle 1.
  task automatic test_basic();
    clear_counts();
    step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(8'h4A >> i, 1'b1);
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL basic_early_data: got %h want 00", data_out); end
    step(1'b1, 1'b1);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", valid); end
    vectors++; if (data_out !== 8'h4A) begin miscompares++; $display("FAIL basic_data: got %h want 4a", data_out); end
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL basic_cnt: got %0d want 1", frame_cnt); end
    step(1'b1, 1'b1);
    vectors++; if (n_valid !== 1) begin miscompares++; $display("FAIL basic_valid_count: got %0d want 1", n_valid); end
    vectors++; if (n_busy !== 9) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 9", n_busy); end
  endtask

  task automatic test_frame_err();
    int busy_hold;
    clear_counts();
    send_frame(8'h4A, 1'b0);
    vectors++; if ({frame_err, valid} !== 2'b10) begin miscompares++; $display("FAIL err_pulse: got %b want 10", {frame_err, valid}); end
    busy_hold = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      busy_hold += int'(busy);
    end
    vectors++; if (busy_hold !== 0) begin miscompares++; $display("FAIL err_held_low_busy: got %0d want 0", busy_hold); end
    step(1'b1, 1'b1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL err_release_busy: got %b want 0", busy); end
    vectors++; if (n_err !== 1) begin miscompares++; $display("FAIL err_count: got %0d want 1", n_err); end
    vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL err_valid: got %0d want 0", n_valid); end
    vectors++; if ({data_out, frame_cnt} !== {8'h4A, 8'd1}) begin miscompares++; $display("FAIL err_hold: got %h want 4a01", {data_out, frame_cnt}); end
  endtask

  // Each bit is strobed on every 4th cycle; the line carries the opposite value otherwise.
  task automatic test_enable();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      for (int g = 0; g < 3; g++) step(~fr[k], 1'b0);
      step(fr[k], 1'b1);
    end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL en_valid: got %b want 1", valid); end
    vectors++; if (data_out !== 8'hA5) begin miscompares++; $display("FAIL en_data: got %h want a5", data_out); end
    vectors++; if (frame_cnt !== 8'd2) begin miscompares++; $display("FAIL en_cnt: got %0d want 2", frame_cnt); end
    step(1'b0, 1'b0);
    vectors++; if ({valid, busy} !== 2'b00) begin miscompares++; $display("FAIL en_after: got %b want 00", {valid, busy}); end
    vectors++; if (n_busy !== 36) begin miscompares++; $display("FAIL en_busy_cycles: got %0d want 36", n_busy); end
    vectors++; if (n_valid + n_err !== 1) begin miscompares++; $display("FAIL en_pulses: got %0d want 1", n_valid + n_err); end
  endtask

  task automatic test_invert();
    clear_counts();
    send_frame(8'h4A, 1'b1);
    vectors++; if (valid_i !== 1'b1) begin miscompares++; $display("FAIL inv_valid: got %b want 1", valid_i); end
    vectors++; if (data_out_i !== 8'h4A) begin miscompares++; $display("FAIL inv_data: got %h want 4a", data_out_i); end
    vectors++; if (frame_cnt_i !== 8'd3) begin miscompares++; $display("FAIL inv_cnt: got %0d want 3", frame_cnt_i); end
    step(1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(8'h81, 1'b1);
    vectors++; if ({valid, data_out} !== {1'b1, 8'h81}) begin miscompares++; $display("FAIL b2b_first: got %h want 181", {valid, data_out}); end
    send_frame(8'h7E, 1'b1);
    vectors++; if ({valid, data_out} !== {1'b1, 8'h7E}) begin miscompares++; $display("FAIL b2b_second: got %h want 17e", {valid, data_out}); end
    vectors++; if (frame_cnt !== 8'd5) begin miscompares++; $display("FAIL b2b_cnt: got %0d want 5", frame_cnt); end
    step(1'b1, 1'b1);
  endtask

  task automatic test_midreset();
    clear_counts();
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    vectors++; if ({busy, data_out, frame_cnt} !== 17'h0) begin miscompares++; $display("FAIL mid_async_clear: got %h want 0", {busy, data_out, frame_cnt}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_no_resume: got %b want 0", busy); end
    clear_counts();
    send_frame(8'h3C, 1'b1);
    vectors++; if (data_out !== 8'h3C) begin miscompares++; $display("FAIL mid_data: got %h want 3c", data_out); end
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL mid_cnt: got %0d want 1", frame_cnt); end
    step(1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 255; i++) send_frame(8'(i), 1'b1);
    vectors++; if (frame_cnt !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
    send_frame(8'hE7, 1'b1);
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_zero: got %0d want 0", frame_cnt); end
    vectors++; if ({valid, data_out} !== {1'b1, 8'hE7}) begin miscompares++; $display("FAIL wrap_last: got %h want 1e7", {valid, data_out}); end
    vectors++; if (n_valid !== 256) begin miscompares++; $display("FAIL wrap_valid_count: got %0d want 256", n_valid); end
    vectors++; if (n_both !== 0) begin miscompares++; $display("FAIL valid_and_err_overlap: got %0d want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_enable();
    test_invert();
    test_back_to_back();
    test_midreset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_frame_collector.md
SERIAL_FRAME_COLLECTOR -- requirements
Module: serial_frame_collector

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the number of data bits per frame (legal range 2..16).
REQ-002 The block SHALL have parameter INVERT, default 0; when 1, the serial input is inverted before use so the Qbar output of the flip-flop stage can drive it.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port D_in SHALL be an input, 1 bit: the serial line, driven by Q (or Qbar) of the upstream ms_sr_flip_flop stage.
REQ-006 Port en SHALL be an input, 1 bit: sample strobe; D_in is sampled only on rising edges where en=1.
REQ-007 Port data_out SHALL be an output, DATA_W bits: the last correctly framed word.
REQ-008 Port valid SHALL be an output, 1 bit: one-cycle pulse marking a new data_out.
REQ-009 Port busy SHALL be an output, 1 bit: high while a frame is in progress (states DATA and STOP).
REQ-010 Port frame_err SHALL be an output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 Port frame_cnt SHALL be an output, 8 bits: count of good frames received.

Function
REQ-012 Line format SHALL be: idle=1; one start bit=0; DATA_W data bits, LSB first; one stop bit=1 (all after optional INVERT).
REQ-013 The FSM SHALL have exactly the states IDLE, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE: a sample of 0 SHALL go to DATA and clear bit_cnt; a sample of 1 SHALL stay in IDLE.
REQ-015 DATA: each sample SHALL shift into the shift register at the MSB end (so the first bit lands at bit 0 after DATA_W shifts) and increment bit_cnt.
REQ-016 DATA: the sample that makes bit_cnt reach DATA_W SHALL move the FSM to STOP.
REQ-017 STOP, sample=1: on that same edge, data_out SHALL load the shift register, valid SHALL go high for exactly one cycle, frame_cnt SHALL increment, and the FSM SHALL return to IDLE.
REQ-018 STOP, sample=0: frame_err SHALL pulse for one cycle, data_out and frame_cnt SHALL be unchanged, and the FSM SHALL go to WAIT_HIGH.
REQ-019 WAIT_HIGH: the FSM SHALL go to IDLE on a sample of 1; a 0 SHALL keep it in WAIT_HIGH (a held-low line is never taken as a start bit).
REQ-020 When en=0, the state, bit_cnt and the shift register SHALL hold, and valid and frame_err SHALL be 0 on the following cycle.
REQ-021 frame_cnt SHALL wrap from 255 to 0 with no flag.
REQ-022 valid and frame_err SHALL never be high in the same cycle.
REQ-023 Back-to-back frames SHALL be accepted: a start bit on the sample immediately after a good stop bit SHALL be recognised.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from D_in or en to any output.

Reset
REQ-025 rst_n=0 SHALL immediately, asynchronously, force: state=IDLE; bit_cnt=0; shift register=0; data_out=0; valid=0; busy=0; frame_err=0; frame_cnt=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a new start bit.
REQ-027 The first rising clk edge after rst_n returns to 1 SHALL be a normal operating edge.

Verification
REQ-028 DATA_W=8, en=1 every cycle, serial stream 0,1,0,1,0,0,1,0,1,1 -> valid pulses once, data_out=8'h4A, frame_cnt=1, busy high for 9 cycles.
REQ-029 Same frame but stop bit=0, then line held 0 for 5 samples, then 1 -> frame_err pulses once, data_out unchanged, FSM stays out of DATA until the 1 arrives, valid stays 0.
REQ-030 en asserted only every 4th cycle, frame carrying 8'hA5 -> data_out=8'hA5, and D_in glitches while en=0 have no effect.
REQ-031 INVERT=1, the bit-complement of the REQ-028 stream applied -> data_out=8'h4A.
REQ-032 rst_n pulsed low after 4 data bits, then a full frame carrying 8'h3C -> data_out=8'h3C, frame_cnt=1.
REQ-033 256 good back-to-back frames -> frame_cnt wraps to 0, with a valid pulse on every frame.
